// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_LOAD       = 2'd1,
      ST_WAIT_START = 2'd2,
      ST_WAIT_DONE  = 2'd3
   } sched_state_t;

   localparam int DEF_START_TIMEOUT = 15;
   localparam int BYTE_W            = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past ptr and wraps,
// considering only requesters enabled by mask.
module rr_arbiter #(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   input  logic [NREQ-1:0]         mask,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] idx,
   output logic                    hit
);

   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0] elig_s;

   assign elig_s = req & mask;

   // first eligible requester after the pointer wins
   always_comb begin
      int            cand_s;
      logic [IDW-1:0] cand_idx_s;
      gnt        = {NREQ{1'b0}};
      idx        = {IDW{1'b0}};
      hit        = 1'b0;
      cand_s     = 0;
      cand_idx_s = {IDW{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         cand_s     = (int'(ptr) + k) % NREQ;
         cand_idx_s = cand_s[IDW-1:0];
         if (!hit && elig_s[cand_idx_s]) begin
            hit             = 1'b1;
            idx             = cand_idx_s;
            gnt[cand_idx_s] = 1'b1;
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NREQ byte requesters with round-robin
// arbitration, message locking and a start-of-frame stall timeout.
module uart_tx_sched
   import uart_sched_pkg::*;
#(
   parameter int NREQ          = 4,
   parameter int START_TIMEOUT = DEF_START_TIMEOUT
) (
   input  logic                     txclk,
   input  logic                     reset_n,
   input  logic                     en,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*BYTE_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic                     ld_tx_data,
   output logic [BYTE_W-1:0]        tx_data,
   output logic                     tx_enable,
   input  logic                     tx_empty,
   output logic [$clog2(NREQ)-1:0]  gnt_id,
   output logic                     busy,
   input  logic                     err_clr,
   output logic                     err_timeout
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(START_TIMEOUT + 1);

   sched_state_t       state_r,  state_nxt_s;
   logic [IDW-1:0]     ptr_r,    ptr_nxt_s;
   logic [IDW-1:0]     gnt_r,    gnt_nxt_s;
   logic               lock_r,   lock_nxt_s;
   logic [CW-1:0]      cnt_r,    cnt_nxt_s;
   logic [BYTE_W-1:0]  data_r,   data_nxt_s;
   logic [NREQ-1:0]    ready_r,  ready_nxt_s;
   logic               ld_r,     ld_nxt_s;
   logic               err_r,    err_nxt_s;
   logic               busy_r;
   logic               txen_r;
   logic               timeout_s;
   logic [NREQ-1:0]    lock_mask_s;
   logic [NREQ-1:0]    arb_gnt_s;
   logic [IDW-1:0]     arb_idx_s;
   logic               arb_hit_s;
   logic [BYTE_W-1:0]  win_data_s;

   // while locked only the owner may win, even with its valid low
   always_comb begin
      if (lock_r) begin
         lock_mask_s = NREQ'(1'b1) << gnt_r;
      end else begin
         lock_mask_s = {NREQ{1'b1}};
      end
   end

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req  (req_valid),
      .ptr  (ptr_r),
      .mask (lock_mask_s),
      .gnt  (arb_gnt_s),
      .idx  (arb_idx_s),
      .hit  (arb_hit_s)
   );

   // one-hot mux of the winning requester's byte
   always_comb begin
      win_data_s = {BYTE_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         win_data_s = win_data_s | (req_data[i*BYTE_W +: BYTE_W] & {BYTE_W{arb_gnt_s[i]}});
      end
   end

   // next-state and next-output logic
   always_comb begin
      state_nxt_s = state_r;
      ptr_nxt_s   = ptr_r;
      gnt_nxt_s   = gnt_r;
      lock_nxt_s  = lock_r;
      cnt_nxt_s   = cnt_r;
      data_nxt_s  = data_r;
      ready_nxt_s = {NREQ{1'b0}};
      ld_nxt_s    = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (en && tx_empty && arb_hit_s) begin
               state_nxt_s = ST_LOAD;
               data_nxt_s  = win_data_s;
               gnt_nxt_s   = arb_idx_s;
               ptr_nxt_s   = arb_idx_s;
               ld_nxt_s    = 1'b1;
               ready_nxt_s = arb_gnt_s;
               lock_nxt_s  = ~req_last[arb_idx_s];
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            state_nxt_s = ST_WAIT_START;
            cnt_nxt_s   = {CW{1'b0}};
         end
         ST_WAIT_START: begin
            if (!tx_empty) begin
               state_nxt_s = ST_WAIT_DONE;
            end else if (cnt_r == CW'(START_TIMEOUT - 1)) begin
               state_nxt_s = ST_IDLE;
               lock_nxt_s  = 1'b0;
               timeout_s   = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CW'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (tx_empty) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_WAIT_DONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
      // a timeout firing together with err_clr keeps the flag set
      if (timeout_s) begin
         err_nxt_s = 1'b1;
      end else if (err_clr) begin
         err_nxt_s = 1'b0;
      end else begin
         err_nxt_s = err_r;
      end
   end

   // state and registered outputs
   always_ff @(posedge txclk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         ptr_r   <= IDW'(NREQ - 1);
         gnt_r   <= {IDW{1'b0}};
         lock_r  <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         data_r  <= {BYTE_W{1'b0}};
         ready_r <= {NREQ{1'b0}};
         ld_r    <= 1'b0;
         err_r   <= 1'b0;
         busy_r  <= 1'b0;
         txen_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
         gnt_r   <= gnt_nxt_s;
         lock_r  <= lock_nxt_s;
         cnt_r   <= cnt_nxt_s;
         data_r  <= data_nxt_s;
         ready_r <= ready_nxt_s;
         ld_r    <= ld_nxt_s;
         err_r   <= err_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         txen_r  <= en;
      end
   end

   assign req_ready   = ready_r;
   assign ld_tx_data  = ld_r;
   assign tx_data     = data_r;
   assign tx_enable   = txen_r;
   assign gnt_id      = gnt_r;
   assign busy        = busy_r;
   assign err_timeout = err_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: requester drivers, a simple UART
// model, and a monitor that checks every load against expected grants.
module tb_uart_tx_sched;

   localparam int NREQ  = 4;
   localparam int FRAME = 10;

   logic        txclk     = 1'b0;
   logic        reset_n   = 1'b1;
   logic        en        = 1'b0;
   logic        err_clr   = 1'b0;
   logic [3:0]  req_valid = 4'b0;
   logic [3:0]  req_last  = 4'b0;
   logic [31:0] req_data  = 32'h0;
   logic [3:0]  req_ready;
   logic        ld_tx_data;
   logic [7:0]  tx_data;
   logic        tx_enable;
   logic        tx_empty;
   logic [1:0]  gnt_id;
   logic        busy;
   logic        err_timeout;

   logic        uart_on = 1'b1;
   logic        u_empty = 1'b1;
   int          u_cnt   = 0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [7:0] d;
      logic       l;
      int         gap;
   } ent_t;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] d;
   } exp_t;

   ent_t mem [4][16];
   int   wp [4];
   int   rp [4];
   int   gap_c [4];
   exp_t sb_q [$];
   exp_t mon_e;

   uart_tx_sched #(.NREQ(NREQ), .START_TIMEOUT(15)) dut (
      .txclk       (txclk),
      .reset_n     (reset_n),
      .en          (en),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .ld_tx_data  (ld_tx_data),
      .tx_data     (tx_data),
      .tx_enable   (tx_enable),
      .tx_empty    (tx_empty),
      .gnt_id      (gnt_id),
      .busy        (busy),
      .err_clr     (err_clr),
      .err_timeout (err_timeout)
   );

   always #5 txclk = ~txclk;

   // UART model: a load makes it busy for FRAME cycles
   always @(posedge txclk or negedge reset_n) begin
      if (!reset_n) begin
         u_empty <= 1'b1;
         u_cnt   <= 0;
      end else if (u_cnt != 0) begin
         u_cnt <= u_cnt - 1;
         if (u_cnt == 1) u_empty <= 1'b1;
      end else if (ld_tx_data && uart_on) begin
         u_empty <= 1'b0;
         u_cnt   <= FRAME;
      end
   end

   assign tx_empty = u_empty | ~uart_on;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   task automatic enq(input int r, input logic [7:0] dv, input logic lv, input int gv);
      mem[r][wp[r]] = '{dv, lv, gv};
      wp[r]++;
   endtask

   task automatic expect_b(input int id, input logic [7:0] dv);
      sb_q.push_back({2'(id), dv});
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_req_ready"},   req_ready,   32'h0);
      chk({nm, "_ld_tx_data"},  ld_tx_data,  32'h0);
      chk({nm, "_tx_data"},     tx_data,     32'h0);
      chk({nm, "_tx_enable"},   tx_enable,   32'h0);
      chk({nm, "_gnt_id"},      gnt_id,      32'h0);
      chk({nm, "_busy"},        busy,        32'h0);
      chk({nm, "_err_timeout"}, err_timeout, 32'h0);
   endtask

   task automatic do_reset(input string nm);
      @(negedge txclk);
      reset_n = 1'b0;
      #1 chk_zero(nm);
      @(negedge txclk);
      reset_n = 1'b1;
   endtask

   task automatic wait_ld(input string nm);
      int t = 0;
      do begin
         @(negedge txclk);
         t++;
      end while (!ld_tx_data && t < 500);
      chk({nm, "_load_seen"}, ld_tx_data, 32'h1);
   endtask

   task automatic wait_idle(input string nm);
      int t = 0;
      repeat (3) @(negedge txclk);
      while ((sb_q.size() != 0 || busy) && t < 3000) begin
         @(negedge txclk);
         t++;
      end
      chk({nm, "_drained"}, (sb_q.size() == 0 && !busy), 32'h1);
   endtask

   // requester drivers: pop on ready, present the next byte after its gap
   initial forever begin
      @(negedge txclk);
      for (int i = 0; i < 4; i++) begin
         if (req_ready[i] && req_valid[i]) begin
            rp[i]++;
            gap_c[i] = (rp[i] < wp[i]) ? mem[i][rp[i]].gap : 0;
         end
         if (gap_c[i] > 0) begin
            req_valid[i] = 1'b0;
            gap_c[i]--;
         end else if (rp[i] < wp[i]) begin
            req_valid[i]       = 1'b1;
            req_data[i*8 +: 8] = mem[i][rp[i]].d;
            req_last[i]        = mem[i][rp[i]].l;
         end else begin
            req_valid[i] = 1'b0;
         end
      end
   end

   // monitor: every load must match the head of the scoreboard
   initial forever begin
      @(negedge txclk);
      if (reset_n && ld_tx_data) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_load: got id %0d data %02h, required no load", gnt_id, tx_data);
         end else begin
            mon_e = sb_q.pop_front();
            chk("grant_id",  gnt_id,    mon_e.id);
            chk("tx_data",   tx_data,   mon_e.d);
            chk("req_ready", req_ready, 32'h1 << mon_e.id);
         end
      end else if (reset_n) begin
         chk("ready_idle", req_ready, 32'h0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      #2 reset_n = 1'b0;
      #1 chk_zero("reset");
      @(negedge txclk);
      @(negedge txclk);
      reset_n = 1'b1;

      // single byte from requester 2
      en = 1'b1;
      enq(2, 8'hA5, 1'b1, 0);
      expect_b(2, 8'hA5);
      wait_ld("t1");
      @(negedge txclk);
      chk("t1_busy", busy, 32'h1);
      chk("t1_tx_enable", tx_enable, 32'h1);
      wait_idle("t1");

      // fairness
      do_reset("t2_reset");
      enq(0, 8'h10, 1'b1, 0); enq(0, 8'h14, 1'b1, 0);
      enq(1, 8'h21, 1'b1, 0); enq(1, 8'h25, 1'b1, 0);
      enq(2, 8'h32, 1'b1, 0);
      enq(3, 8'h43, 1'b1, 0);
      expect_b(0, 8'h10); expect_b(1, 8'h21); expect_b(2, 8'h32);
      expect_b(3, 8'h43); expect_b(0, 8'h14); expect_b(1, 8'h25);
      wait_idle("t2");

      // lock: requester 1 message holds off requester 0, even across a gap
      do_reset("t3_reset");
      enq(0, 8'h01, 1'b1, 0); enq(0, 8'h02, 1'b1, 0);
      enq(1, 8'h11, 1'b0, 0); enq(1, 8'h22, 1'b0, 20); enq(1, 8'h33, 1'b1, 0);
      expect_b(0, 8'h01); expect_b(1, 8'h11); expect_b(1, 8'h22);
      expect_b(1, 8'h33); expect_b(0, 8'h02);
      wait_idle("t3");

      // start timeout with the UART disconnected
      uart_on = 1'b0;
      enq(3, 8'h5A, 1'b1, 0);
      expect_b(3, 8'h5A);
      wait_ld("t4");
      cnt = 0;
      while (!err_timeout && cnt < 40) begin
         @(negedge txclk);
         cnt++;
      end
      chk("t4_timeout_cycles", cnt, 32'd16);
      chk("t4_busy_after", busy, 32'h0);
      repeat (3) @(negedge txclk);
      chk("t4_err_sticky", err_timeout, 32'h1);
      err_clr = 1'b1;
      @(negedge txclk);
      err_clr = 1'b0;
      chk("t4_err_cleared", err_timeout, 32'h0);
      uart_on = 1'b1;

      // enable drop in WAIT_DONE
      enq(0, 8'h61, 1'b1, 0); enq(1, 8'h72, 1'b1, 0); enq(2, 8'h83, 1'b1, 0);
      expect_b(0, 8'h61);
      wait_ld("t5");
      @(negedge txclk);
      @(negedge txclk);
      chk("t5_in_frame", tx_empty, 32'h0);
      en = 1'b0;
      chk("t5_tx_enable_hold", tx_enable, 32'h1);
      @(negedge txclk);
      chk("t5_tx_enable_low", tx_enable, 32'h0);
      wait_idle("t5a");
      repeat (20) @(negedge txclk);
      chk("t5_no_service", busy, 32'h0);
      expect_b(1, 8'h72); expect_b(2, 8'h83);
      en = 1'b1;
      wait_idle("t5b");

      // reset in WAIT_START
      enq(2, 8'h9C, 1'b1, 0);
      expect_b(2, 8'h9C);
      wait_ld("t6");
      @(negedge txclk);
      chk("t6_busy_before", busy, 32'h1);
      #2 reset_n = 1'b0;
      #1 chk_zero("t6_reset");
      @(negedge txclk);
      reset_n = 1'b1;
      enq(3, 8'hD3, 1'b1, 0);
      enq(0, 8'h0E, 1'b1, 0);
      expect_b(0, 8'h0E); expect_b(3, 8'hD3);
      wait_idle("t6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares the `uart` transmitter among `NREQ` byte requesters on the `txclk` domain. Each requester presents a byte with a valid/ready handshake. A round-robin arbiter picks one requester, and the block drives `ld_tx_data`, `tx_data` and `tx_enable` into the UART and tracks `tx_empty` until the byte has gone out. Requesters can lock the grant for a multi-byte message, and a stall timeout catches a transmitter that never accepts a byte.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `START_TIMEOUT`, default 15: maximum number of `txclk` cycles to wait for `tx_empty` to fall after a load.

Ports:
- `txclk` in 1: sole clock, the same clock as the UART `txclk`.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: scheduler enable.
- `req_valid` in NREQ: per-requester byte valid.
- `req_data` in NREQ*8: byte for requester i on bits [8i+7:8i].
- `req_last` in NREQ: marks the byte as the last of a message.
- `req_ready` out NREQ: one-hot, one-cycle acceptance pulse.
- `ld_tx_data` out 1: to UART, load strobe.
- `tx_data` out 8: to UART, byte to send.
- `tx_enable` out 1: to UART, registered copy of `en`.
- `tx_empty` in 1: from UART, high when the transmitter is idle.
- `gnt_id` out clog2(NREQ): index of the current or last granted requester.
- `busy` out 1: high in any state other than IDLE.
- `err_clr` in 1: clears `err_timeout`.
- `err_timeout` out 1: sticky flag, set when a start timeout fires.

## Operation
All outputs are registered. Reset values:
- `req_ready`, `ld_tx_data`, `tx_data`, `tx_enable`, `gnt_id`, `busy`, `err_timeout` are all 0.
- State is IDLE, the round-robin pointer is NREQ-1 (so requester 0 has first priority), and the lock is clear.

FSM states are IDLE, LOAD, WAIT_START and WAIT_DONE.
- **IDLE → LOAD.** Taken when `en`=1, `tx_empty`=1 and at least one eligible requester has `req_valid`=1.
  - With the lock clear, every requester is eligible. With the lock set, only `gnt_id` is eligible.
  - On that edge the block captures `req_data` of the winner into `tx_data` and sets `gnt_id`.
  - It also sets `ld_tx_data`=1 and the winner's `req_ready` bit to 1.
  - It sets the lock to the inverse of the winner's `req_last`, and moves the round-robin pointer to the winner.
- **LOAD → WAIT_START.** Unconditional after one cycle. `ld_tx_data` and `req_ready` return to 0.
- **WAIT_START.**
  - When `tx_empty`=0, go to WAIT_DONE.
  - Otherwise increment the cycle counter. When it reaches `START_TIMEOUT`, set `err_timeout`, clear the lock and go to IDLE.
- **WAIT_DONE → IDLE.** Taken when `tx_empty`=1.
- **Round robin.** The search starts at pointer+1 and wraps modulo NREQ. The lowest index after the pointer wins.
- **Lock.** While the lock is set, other requesters starve, even when the owner's `req_valid` is low. The lock clears only when the owner sends a byte with `req_last`=1, on a timeout, or on reset.
- **`en`=0 mid-byte.** The byte in flight completes and no new arbitration happens. `tx_enable` follows `en` one cycle later. The lock is preserved.
- **Handshake.**
  - A requester holds `req_valid`, `req_data` and `req_last` stable until it sees its `req_ready` bit.
  - Deasserting `req_valid` before acceptance is legal. The byte is then not sent.
- **`err_clr`.** Clears `err_timeout`. If a timeout fires in the same cycle, the set wins.

## Timing
- **Sampling and load.** A request is sampled at edge k while in IDLE. `ld_tx_data` and `req_ready` are high for exactly the cycle between edges k and k+1.
- **Completion.** `busy` falls on the edge after `tx_empty` is seen high in WAIT_DONE.
- **Back-to-back bytes.** Minimum spacing is 1 LOAD cycle, at least 1 WAIT_START cycle, the UART frame time, and 1 IDLE cycle. The next `ld_tx_data` follows at the earliest one edge after the return to IDLE.
- **Timeout.** `err_timeout` rises exactly `START_TIMEOUT` cycles after entering WAIT_START if `tx_empty` stays 1.
- **Asynchronous reset.** Asserting `reset_n` low in any state forces the reset values immediately. The partially sent UART byte is abandoned.

## Structure
- Package `uart_sched_pkg` holds:
  - the FSM state encoding (IDLE=0, LOAD=1, WAIT_START=2, WAIT_DONE=3);
  - the default `START_TIMEOUT`;
  - the byte width constant (8).
- Sub-module `rr_arbiter` is a purely combinational round-robin pick.
  - Inputs: request vector, pointer and lock mask.
  - Outputs: one-hot grant and index.
- FSM, counter, lock and output registers live in `uart_tx_sched`.

## Test plan
- **Single byte.** Reset, then `en`=1, with requester 2 sending `req_data`=0xA5 and `req_last`=1.
  - `ld_tx_data` pulses once with `tx_data`=0xA5; `req_ready`=4'b0100 for one cycle; `gnt_id`=2.
  - `busy` falls after the UART returns `tx_empty`=1.
- **Fairness.** All 4 requesters hold valid continuously with `req_last`=1.
  - The grant order is 0,1,2,3,0,1.
  - Each requester gets exactly one `req_ready` per round.
- **Lock.** Requester 1 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while requester 0 is valid.
  - The three bytes go out consecutively, then requester 0 is served.
  - The lock holds even while requester 1 drops valid for 20 cycles between bytes.
- **Timeout.** Tie `tx_empty`=1 with the UART disconnected, and request a byte.
  - `err_timeout` rises 15 cycles after LOAD and the FSM returns to IDLE.
  - After `err_clr`, `err_timeout` reads 0.
- **Enable drop.** Pull `en` low in WAIT_DONE.
  - The in-flight byte completes, `tx_enable`=0 one cycle later, and no new `ld_tx_data` appears while other requesters are valid.
  - After `en`=1, service resumes from the next round-robin index.
- **Reset mid-byte.** Pull `reset_n` low in WAIT_START.
  - All outputs go to 0 immediately without waiting for a clock edge.
  - After release, requester 0 has first priority.
